// File: rtl/mc_timed_req_queue.sv
// Purpose: in-order queue of timed DDR4 requests with per-bank open-row state and completion scheduling.
// Latency: entry visible on cmp_* one cycle after accept; cmp_valid_o asserts once now reaches the entry's done time.
// Backpressure: req_ready_o is a registered not-full flag; cmp_valid_o and the head fields hold until cmp_ready_i.
module mc_timed_req_queue #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 32,
    parameter int T_RP  = 24,
    parameter int T_RCD = 24,
    parameter int T_CL  = 24,
    parameter int T_CWD = 20
) (
    input  logic                     clk,
    input  logic                     rst_n,
    // request side
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [1:0]               req_op_i,
    input  logic [31:0]              req_addr_i,
    // completion side
    output logic                     cmp_valid_o,
    input  logic                     cmp_ready_i,
    output logic [1:0]               cmp_op_o,
    output logic [31:0]              cmp_addr_o,
    output logic [CNT_W-1:0]         cmp_arrival_o,
    output logic [CNT_W-1:0]         cmp_done_o,
    output logic [1:0]               cmp_class_o,
    // status
    output logic                     illegal_op_o,
    output logic [$clog2(DEPTH):0]   occupancy_o,
    output logic [CNT_W-1:0]         now_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int NBANK = 16;

    localparam logic [1:0] OP_WRITE   = 2'd1;
    localparam logic [1:0] OP_ILLEGAL = 2'd3;

    typedef enum logic [1:0] {
        CLS_HIT      = 2'd0,
        CLS_EMPTY    = 2'd1,
        CLS_CONFLICT = 2'd2
    } cls_e;

    typedef struct packed {
        logic [1:0]       op;
        logic [31:0]      addr;
        logic [CNT_W-1:0] arrival;
        logic [CNT_W-1:0] done;
        cls_e             cls;
    } entry_t;

    // Wrap-safe "a is at or after b": the modular difference is non-negative.
    function automatic logic later_eq(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
        logic [CNT_W-1:0] diff;
        diff = a - b;
        return ~diff[CNT_W-1];
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] now_q,       now_d;
    logic [CNT_W-1:0] last_done_q, last_done_d;
    logic [OCC_W-1:0] occ_q,       occ_d;
    logic [PTR_W-1:0] wr_ptr_q,    wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,    rd_ptr_d;
    logic             ready_q,     ready_d;
    logic             illegal_q,   illegal_d;

    logic [NBANK-1:0] open_valid_q;
    logic [13:0]      open_row_q [NBANK];

    entry_t           mem_q [DEPTH];

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic             accept;
    logic             is_illegal;
    logic             push;
    logic             pop;
    logic [3:0]       bank;
    logic [13:0]      row;
    cls_e             cls_d;
    logic [CNT_W-1:0] cas;
    logic [CNT_W-1:0] lat;
    logic [CNT_W-1:0] start;
    logic [CNT_W-1:0] done_new;
    entry_t           new_entry;
    entry_t           head;
    logic             occ_nz;

    assign accept     = req_valid_i && ready_q;
    assign is_illegal = (req_op_i == OP_ILLEGAL);
    assign push       = accept && !is_illegal;
    assign pop        = cmp_valid_o && cmp_ready_i;
    assign bank       = {req_addr_i[7:6], req_addr_i[9:8]};
    assign row        = req_addr_i[31:18];

    // Classify the offered request against the open row of its bank.
    always_comb begin
        cls_d = CLS_CONFLICT;
        if (!open_valid_q[bank]) begin
            cls_d = CLS_EMPTY;
        end else if (open_row_q[bank] == row) begin
            cls_d = CLS_HIT;
        end
    end

    // Service latency from row class and CAS flavour (writes use the write CAS).
    always_comb begin
        cas = (req_op_i == OP_WRITE) ? CNT_W'(T_CWD) : CNT_W'(T_CL);
        lat = cas;
        unique case (cls_d)
            CLS_EMPTY:    lat = CNT_W'(T_RCD) + cas;
            CLS_CONFLICT: lat = CNT_W'(T_RP) + CNT_W'(T_RCD) + cas;
            default:      lat = cas;
        endcase
    end

    // Serialise behind the previous request. An empty queue means every
    // scheduled completion has already been retired, so last_done is in the
    // past; starting at now avoids a stale last_done aliasing as "future"
    // after the counter has run more than half its range.
    always_comb begin
        start = now_q;
        if (occ_nz && !later_eq(now_q, last_done_q)) begin
            start = last_done_q;
        end
        done_new = start + lat;
    end

    // Entry written into the queue on a legal accept.
    always_comb begin
        new_entry         = '0;
        new_entry.op      = req_op_i;
        new_entry.addr    = req_addr_i;
        new_entry.arrival = now_q;
        new_entry.done    = done_new;
        new_entry.cls     = cls_d;
    end

    // ------------------------------------------------------------------
    // Head presentation
    // ------------------------------------------------------------------
    assign occ_nz = (occ_q != '0);
    assign head   = mem_q[rd_ptr_q];

    assign cmp_valid_o   = occ_nz && later_eq(now_q, head.done);
    assign cmp_op_o      = occ_nz ? head.op      : 2'd0;
    assign cmp_addr_o    = occ_nz ? head.addr    : 32'd0;
    assign cmp_arrival_o = occ_nz ? head.arrival : '0;
    assign cmp_done_o    = occ_nz ? head.done    : '0;
    assign cmp_class_o   = occ_nz ? head.cls     : 2'd0;

    assign req_ready_o  = ready_q;
    assign illegal_op_o = illegal_q;
    assign occupancy_o  = occ_q;
    assign now_o        = now_q;

    // ------------------------------------------------------------------
    // Next-state for counters, pointers and flags
    // ------------------------------------------------------------------
    // Next-state of the time base, queue bookkeeping and status flags.
    always_comb begin
        now_d       = now_q + CNT_W'(1);
        last_done_d = last_done_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occ_d       = occ_q;

        if (push) begin
            last_done_d = done_new;
            wr_ptr_d    = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        unique case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase

        // Registered not-full: a pop while full only raises ready next cycle.
        ready_d   = (occ_d < OCC_W'(DEPTH));
        illegal_d = accept && is_illegal;
    end

    // Register the time base, queue bookkeeping and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            now_q       <= '0;
            last_done_q <= '0;
            occ_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ready_q     <= 1'b1;
            illegal_q   <= 1'b0;
        end else begin
            now_q       <= now_d;
            last_done_q <= last_done_d;
            occ_q       <= occ_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ready_q     <= ready_d;
            illegal_q   <= illegal_d;
        end
    end

    // Open-page policy: every legal accept leaves its row open in its bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            open_valid_q <= '0;
            for (int i = 0; i < NBANK; i++) begin
                open_row_q[i] <= '0;
            end
        end else if (push) begin
            open_valid_q[bank] <= 1'b1;
            open_row_q[bank]   <= row;
        end
    end

    // Entry storage; contents are masked by occupancy so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= new_entry;
        end
    end

endmodule
